beat_period_meter: RTL and testbench



---
 rtl/beat_period_meter.sv | 155 +++++++++++++++
 tb/tb_beat_period_meter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/beat_period_meter.sv
// Beat period meter: measures cycles between beat rising edges, tracks lock and loss.
// Optional BEAT_PERIOD_AVG_EN: period reports a 4-entry running average.
module beat_period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int TOL     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [15:0]      beat_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_TRACK
    } state_t;

    localparam logic [WIDTH-1:0] LP_TO  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] LP_TOL = WIDTH'(TOL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_beat_q;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_diff;
    logic             w_edge;
    logic             w_sat;
    logic             w_meas;
    logic             w_first;
    logic             w_timeout;
    logic             w_stable;

    assign w_edge   = beat & ~r_beat_q;
    assign w_sat    = (r_cnt == LP_TO);
    assign w_diff   = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
    assign w_stable = (w_diff <= LP_TOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An edge always wins over a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_meas      = 1'b0;
        w_first     = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_edge) w_state_nxt = S_FIRST;
            end
            S_FIRST: begin
                if (w_edge) begin
                    w_state_nxt = S_TRACK;
                    w_meas      = 1'b1;
                    w_first     = 1'b1;
                end else if (w_sat) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_TRACK: begin
                if (w_edge) begin
                    w_meas = 1'b1;
                end else if (w_sat) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_q   <= 1'b0;
            r_cnt      <= '0;
            r_prev     <= '0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            beat_count <= '0;
        end else begin
            r_beat_q <= beat;
            if (w_edge) begin
                r_cnt      <= {{(WIDTH-1){1'b0}}, 1'b1};
                beat_count <= beat_count + 16'd1;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_meas) r_prev <= r_cnt;
            if (w_meas && !w_first) begin
                locked <= w_stable;
            end else if (w_timeout) begin
                locked <= 1'b0;
            end
            if (w_timeout) begin
                lost <= 1'b1;
            end else if (w_edge) begin
                lost <= 1'b0;
            end
        end
    end

`ifdef BEAT_PERIOD_AVG_EN
    logic [WIDTH-1:0] r_hist [4];
    logic             r_meas_q;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_avg;

    assign w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
                 + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};
    assign w_avg = WIDTH'(w_sum >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_meas_q     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            if (w_meas && w_first) begin
                for (int i = 0; i < 4; i++) r_hist[i] <= r_cnt;
            end else if (w_meas) begin
                r_hist[0] <= r_cnt;
                for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
            end
            r_meas_q     <= w_meas;
            period_valid <= r_meas_q;
            if (r_meas_q) period <= w_avg;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= w_meas;
            if (w_meas) period <= r_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_beat_period_meter.sv
// Scoreboard bench for beat_period_meter (default and BEAT_PERIOD_AVG_EN builds).
module tb_beat_period_meter;

    localparam int W   = 16;
    localparam int TO  = 120;
    localparam int TL  = 0;
`ifdef BEAT_PERIOD_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int LAT = AVG ? 2 : 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         beat = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         lost;
    logic [15:0]  beat_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int qp[$];
    int qc[$];

    beat_period_meter #(.WIDTH(W), .TIMEOUT(TO), .TOL(TL)) dut (
        .clk          (clk),
        .rst          (rst),
        .beat         (beat),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick(input int d, input int a);
        return AVG ? a : d;
    endfunction

    task automatic tick(input logic b);
        beat = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_period(input int p);
        qp.push_back(p);
        qc.push_back(cyc + LAT - 1);
    endtask

    // gap-1 low cycles then one high cycle: edge interval of gap
    task automatic beat_iv(input int gap, input int exp_p);
        repeat (gap - 1) tick(1'b0);
        tick(1'b1);
        if (exp_p >= 0) expect_period(exp_p);
    endtask

    task automatic apply_reset();
        repeat (3) tick(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && period_valid) begin
            if (qp.size() == 0) begin
                chk("unexpected_period_valid", 1, 0);
            end else begin
                chk("period_value", int'(period), qp.pop_front());
                chk("period_cycle", cyc, qc.pop_front());
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_count", int'(beat_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // alternating beat straight out of reset
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick(1'b0);
            tick(1'b1);
            if (k >= 2) expect_period(2);
            chk("alt_count", int'(beat_count), k);
            if (k == 2) chk("alt_locked_2nd", int'(locked), 0);
            if (k == 3) chk("alt_locked_3rd", int'(locked), 1);
        end

        // steady 100 then a 103 step
        apply_reset();
        tick(1'b1);
        beat_iv(100, 100);
        chk("p100_locked_2nd", int'(locked), 0);
        beat_iv(100, 100);
        chk("p100_locked", int'(locked), 1);
        beat_iv(103, pick(103, 100));
        chk("p103_unlock", int'(locked), 0);
        beat_iv(103, pick(103, 101));
        chk("p103_relock", int'(locked), 1);

        // interval exactly TIMEOUT, then loss
        apply_reset();
        tick(1'b1);
        beat_iv(TO, TO);
        chk("to_edge_lost", int'(lost), 0);
        repeat (TO - 1) tick(1'b0);
        chk("to_before_lost", int'(lost), 0);
        tick(1'b0);
        chk("to_lost", int'(lost), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_period_hold", int'(period), TO);
        tick(1'b1);
        chk("to_relost", int'(lost), 0);
        chk("to_count", int'(beat_count), 3);
        chk("to_period_kept", int'(period), TO);
        repeat (3) tick(1'b0);

        // held-high beat is one edge
        apply_reset();
        tick(1'b0);
        repeat (10) tick(1'b1);
        repeat (3) tick(1'b0);
        chk("held_count", int'(beat_count), 1);

        // async reset while locked
        apply_reset();
        tick(1'b1);
        beat_iv(10, 10);
        beat_iv(10, 10);
        chk("ar_locked", int'(locked), 1);
        repeat (3) tick(1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_period", int'(period), 0);
        chk("ar_valid", int'(period_valid), 0);
        chk("ar_locked0", int'(locked), 0);
        chk("ar_lost", int'(lost), 0);
        chk("ar_count", int'(beat_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // raw periods 8, 8, 12, 12
        tick(1'b1);
        beat_iv(8, 8);
        beat_iv(8, 8);
        beat_iv(12, pick(12, 9));
        beat_iv(12, pick(12, 10));
        repeat (4) tick(1'b0);

        chk("scoreboard_drained", qp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
